// File: rtl/grf_scoreboard_if.sv
// Issue/retire handshake bundle between decode, writeback and the GRF scoreboard.
interface grf_scoreboard_if;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  logic            issue_valid;
  logic [AW-1:0]   issue_rs;
  logic [AW-1:0]   issue_rt;
  logic            issue_use_rs;
  logic            issue_use_rt;
  logic            issue_wr;
  logic [AW-1:0]   issue_dst;
  logic            wb_valid;
  logic [AW-1:0]   wb_addr;
  logic            flush;
  logic            stall;
  logic [NREG-1:0] busy_mask;
  logic            err;

  // Decode/writeback side drives requests and observes the hazard result.
  modport master (
    output issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
    output issue_wr, issue_dst, wb_valid, wb_addr, flush,
    input  stall, busy_mask, err
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
    input  issue_wr, issue_dst, wb_valid, wb_addr, flush,
    output stall, busy_mask, err
  );
endinterface

// File: rtl/grf_scoreboard.sv
// Issue-side hazard scoreboard for the 32x32 GRF: per-register pending-writer
// counters, RAW/WAW-saturation stall, sticky error on retire without writer.
// Optional build macro GRF_SB_WB_BYPASS_EN: a source whose only pending writer
// retires this cycle is treated as ready.
module grf_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic clk,
  input  logic reset,
  grf_scoreboard_if.slave sb
);
  localparam int unsigned NREG = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic             err_q, err_d;

  logic byp_rs, byp_rt, busy_rs, busy_rt, waw_full, stall_c, inc, dec;

  // Hazard detection and accept/retire qualifiers from current state and inputs.
  always_comb begin
`ifdef GRF_SB_WB_BYPASS_EN
    byp_rs = sb.wb_valid && (sb.wb_addr == sb.issue_rs) && (cnt_q[sb.issue_rs] == CNT_ONE);
    byp_rt = sb.wb_valid && (sb.wb_addr == sb.issue_rt) && (cnt_q[sb.issue_rt] == CNT_ONE);
`else
    byp_rs = 1'b0;
    byp_rt = 1'b0;
`endif
    busy_rs  = (sb.issue_rs != 5'd0) && (cnt_q[sb.issue_rs] != '0) && !byp_rs;
    busy_rt  = (sb.issue_rt != 5'd0) && (cnt_q[sb.issue_rt] != '0) && !byp_rt;
    waw_full = sb.issue_wr && (sb.issue_dst != 5'd0) && (cnt_q[sb.issue_dst] == CNT_MAX);
    stall_c  = sb.issue_valid && !sb.flush && !reset &&
               ((sb.issue_use_rs && busy_rs) || (sb.issue_use_rt && busy_rt) || waw_full);
    inc      = sb.issue_valid && !stall_c && sb.issue_wr && (sb.issue_dst != 5'd0) && !sb.flush;
    dec      = sb.wb_valid && (sb.wb_addr != 5'd0) && !sb.flush;
  end

  // Next-state counters, busy mask and sticky error.
  always_comb begin
    err_d  = err_q;
    busy_d = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    cnt_d[0] = '0;
    if (sb.flush) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_d[r] = '0;
      end
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (inc && (sb.issue_dst == 5'(r)) && !(dec && (sb.wb_addr == 5'(r)))) begin
          cnt_d[r] = cnt_q[r] + CNT_ONE;
        end else if (dec && (sb.wb_addr == 5'(r)) && !(inc && (sb.issue_dst == 5'(r)))) begin
          if (cnt_q[r] != '0) begin
            cnt_d[r] = cnt_q[r] - CNT_ONE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    end
    for (int unsigned r = 1; r < NREG; r++) begin
      busy_d[r] = (cnt_d[r] != '0);
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign sb.stall     = stall_c;
  assign sb.busy_mask = busy_q;
  assign sb.err       = err_q;
endmodule
